// File: rtl/multi_project_mux_pkg.sv
// Shared definitions for the multi-project pad/wishbone multiplexer:
// switch-sequencer state encoding, register offsets, window geometry and
// the timeout read-back constant.
package multi_project_mux_pkg;

   // Switch sequencer states; the numeric values are visible in STATUS[1:0]
   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_GAP  = 2'd1,
      ST_PRST = 2'd2
   } state_t;

   // Register offsets inside the register page (page 0)
   localparam logic [7:0]  REG_ACTIVE = 8'h00;
   localparam logic [7:0]  REG_STATUS = 8'h04;

   // Each project owns one 0x100-byte window; page k+1 belongs to project k
   localparam logic [31:0] WIN_SIZE   = 32'h0000_0100;
   localparam int          WIN_SHIFT  = 8;

   // Returned when a forwarded access is never acknowledged by its project
   localparam logic [31:0] DEAD_BEEF  = 32'hDEAD_BEEF;

   // Saturating 8-bit increment used for event counters that must not wrap
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/mux_switch_seq.sv
// Switch sequencer: after a project change the pads are first gated for
// GAP_CYC cycles, then the new project is held in reset for RST_CYC cycles,
// then the project runs. i_clear forces the post-reset PRST phase; i_start
// (an ACTIVE write) restarts the sequence from the first GAP cycle.
module mux_switch_seq
   import multi_project_mux_pkg::*;
#(
   parameter int GAP_CYC = 4,
   parameter int RST_CYC = 8
) (
   input  logic   clk,
   input  logic   i_clear,
   input  logic   i_start,
   output state_t o_state,
   output logic   o_done
);

   localparam int MAX_CYC = (GAP_CYC > RST_CYC) ? GAP_CYC : RST_CYC;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);

   localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYC);
   localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RST_CYC);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;

   // Phase FSM: r_cnt holds the cycles remaining in the current phase,
   // counting the present cycle, so a load of N gives exactly N cycles
   always_ff @(posedge clk) begin
      if (i_clear) begin
         r_state <= ST_PRST;
         r_cnt   <= RST_LOAD;
      end else if (i_start) begin
         r_state <= ST_GAP;
         r_cnt   <= GAP_LOAD;
      end else begin
         case (r_state)
            ST_GAP: begin
               if (r_cnt <= CNT_ONE) begin
                  r_state <= ST_PRST;
                  r_cnt   <= RST_LOAD;
               end else begin
                  r_cnt <= r_cnt - CNT_ONE;
               end
            end
            ST_PRST: begin
               if (r_cnt <= CNT_ONE) begin
                  r_state <= ST_RUN;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt - CNT_ONE;
               end
            end
            default: begin
               r_state <= ST_RUN;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   assign o_state = r_state;
   assign o_done  = (r_state == ST_RUN);

endmodule

// File: rtl/multi_project_mux.sv
// Multi-project multiplexer: connects one of NUM_PROJ user projects to the
// shared pads and forwards wishbone accesses in that project's address
// window. Switching projects gates the pads, pulses the project reset and
// only then hands the pads over. Forwarded accesses are guarded by an ack
// watchdog so a dead project cannot hang the bus.
module multi_project_mux
   import multi_project_mux_pkg::*;
#(
   parameter int          NUM_PROJ = 8,
   parameter int          IO_W     = 38,
   parameter logic [31:0] BASE     = 32'h3000_0000,
   parameter int          GAP_CYC  = 4,
   parameter int          RST_CYC  = 8,
   parameter int          TIMEOUT  = 255
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wbs_cyc_i,
   input  logic                     wbs_stb_i,
   input  logic                     wbs_we_i,
   input  logic [3:0]               wbs_sel_i,
   input  logic [31:0]              wbs_adr_i,
   input  logic [31:0]              wbs_dat_i,
   output logic                     wbs_ack_o,
   output logic [31:0]              wbs_dat_o,
   input  logic [IO_W-1:0]          io_in,
   output logic [IO_W-1:0]          io_out,
   output logic [IO_W-1:0]          io_oeb,
   output logic [NUM_PROJ*IO_W-1:0] proj_io_in,
   input  logic [NUM_PROJ*IO_W-1:0] proj_io_out,
   input  logic [NUM_PROJ*IO_W-1:0] proj_io_oeb,
   output logic [NUM_PROJ-1:0]      proj_reset,
   output logic [NUM_PROJ-1:0]      proj_wb_stb,
   input  logic [NUM_PROJ-1:0]      proj_wb_ack,
   input  logic [NUM_PROJ*32-1:0]   proj_wb_dat
);

   // Decoded span: register page plus one window per project
   localparam logic [31:0] SPAN       = 32'(NUM_PROJ + 1) * WIN_SIZE;
   localparam logic [8:0]  NUM_PROJ_L = 9'(NUM_PROJ);
   localparam int          TO_W       = $clog2(TIMEOUT + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
   localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

   // Bus decode
   logic        w_valid;
   logic        w_write;
   logic [31:0] w_off;
   logic [31-WIN_SHIFT:0] w_page;
   logic        w_in_range;
   logic        w_reg_page;
   logic        w_page_hit;
   logic        w_act_ok;
   logic        w_fwd;
   logic        w_fwd_ack;
   logic        w_int_acc;
   logic        w_act_wr;
   logic        w_timeout;
   logic [31:0] w_reg_rdata;

   // Active-project selection
   logic [IO_W-1:0] w_sel_out;
   logic [IO_W-1:0] w_sel_oeb;
   logic            w_sel_ack;
   logic [31:0]     w_fwd_dat;

   // Sequencer interface
   state_t w_state;
   logic   w_run;
   logic   w_prst;

   // Bus-side state
   logic [7:0]      r_active;
   logic [7:0]      r_sw_cnt;
   logic [7:0]      r_to_events;
   logic [TO_W-1:0] r_to_cnt;
   logic            r_ack;
   logic [31:0]     r_dat;

   // Only the low byte of write data carries a register field
   logic w_unused_dat;
   assign w_unused_dat = ^wbs_dat_i[31:8];

   mux_switch_seq #(
      .GAP_CYC (GAP_CYC),
      .RST_CYC (RST_CYC)
   ) u_seq (
      .clk     (clk),
      .i_clear (reset),
      .i_start (w_act_wr),
      .o_state (w_state),
      .o_done  (w_run)
   );

   assign w_prst = (w_state == ST_PRST);

   assign w_valid    = wbs_cyc_i & wbs_stb_i;
   assign w_write    = wbs_we_i & (|wbs_sel_i);
   assign w_off      = wbs_adr_i - BASE;
   assign w_page     = w_off[31:WIN_SHIFT];
   assign w_in_range = (wbs_adr_i >= BASE) && (w_off < SPAN);
   assign w_reg_page = (w_page == '0);
   assign w_page_hit = (w_page == ({16'd0, r_active} + 24'd1));
   assign w_act_ok   = ({1'b0, r_active} < NUM_PROJ_L);

   // An access is forwarded only to the running, active project's window;
   // everything else in range is answered locally
   assign w_fwd     = w_valid & w_in_range & ~w_reg_page & w_page_hit &
                      w_act_ok & w_run & ~reset;
   assign w_fwd_ack = w_fwd & ~r_ack & w_sel_ack;
   assign w_int_acc = w_valid & w_in_range & ~w_fwd & ~r_ack & ~reset;
   assign w_act_wr  = w_int_acc & w_write & w_reg_page &
                      (w_off[7:0] == REG_ACTIVE) & wbs_sel_i[0];
   assign w_timeout = w_fwd & ~r_ack & ~w_sel_ack & (r_to_cnt == TO_LAST);

   // Register-page read data; unmapped offsets and local window reads give 0
   always_comb begin
      w_reg_rdata = '0;
      if (w_reg_page) begin
         if (w_off[7:0] == REG_ACTIVE) begin
            w_reg_rdata = {24'd0, r_active};
         end else if (w_off[7:0] == REG_STATUS) begin
            w_reg_rdata = {8'd0, r_to_events, r_sw_cnt, 6'd0, w_state};
         end
      end
   end

   // Pick the active project's pads and bus response; "none" leaves defaults
   always_comb begin
      w_sel_out = '0;
      w_sel_oeb = '1;
      w_sel_ack = 1'b0;
      w_fwd_dat = '0;
      for (int k = 0; k < NUM_PROJ; k++) begin
         if (r_active == 8'(k)) begin
            w_sel_out = proj_io_out[k*IO_W +: IO_W];
            w_sel_oeb = proj_io_oeb[k*IO_W +: IO_W];
            w_sel_ack = proj_wb_ack[k];
            w_fwd_dat = proj_wb_dat[k*32 +: 32];
         end
      end
   end

   assign io_out = w_run ? w_sel_out : '0;
   assign io_oeb = w_run ? w_sel_oeb : '1;

   // Per-project fan-out: input pads, reset hold and forwarded strobe
   for (genvar k = 0; k < NUM_PROJ; k++) begin : g_proj
      logic w_is_act;
      assign w_is_act = (r_active == 8'(k));
      assign proj_io_in[k*IO_W +: IO_W] = (w_is_act && (w_run || w_prst)) ? io_in : '0;
      assign proj_reset[k]  = reset | ~w_is_act | ~w_run;
      assign proj_wb_stb[k] = w_is_act & w_fwd & ~r_ack;
   end

   // Local acks, ack watchdog, ACTIVE register and event counters
   always_ff @(posedge clk) begin
      if (reset) begin
         r_active    <= '0;
         r_sw_cnt    <= '0;
         r_to_events <= '0;
         r_to_cnt    <= '0;
         r_ack       <= 1'b0;
         r_dat       <= '0;
      end else begin
         r_ack <= w_int_acc | w_timeout;

         if (w_timeout) begin
            r_dat <= DEAD_BEEF;
         end else if (w_int_acc && !w_write) begin
            r_dat <= w_reg_rdata;
         end else begin
            r_dat <= '0;
         end

         // Counts cycles a forwarded strobe has waited; any other cycle clears it
         if (w_fwd && !r_ack && !w_sel_ack && !w_timeout) begin
            r_to_cnt <= r_to_cnt + TO_ONE;
         end else begin
            r_to_cnt <= '0;
         end

         if (w_timeout) begin
            r_to_events <= sat_inc8(r_to_events);
         end

         if (w_act_wr) begin
            r_active <= wbs_dat_i[7:0];
            r_sw_cnt <= r_sw_cnt + 8'd1;
         end
      end
   end

   assign wbs_ack_o = ~reset & (r_ack | w_fwd_ack);

   // Read data is only ever non-zero alongside an ack
   always_comb begin
      wbs_dat_o = '0;
      if (!reset) begin
         if (r_ack) begin
            wbs_dat_o = r_dat;
         end else if (w_fwd_ack) begin
            wbs_dat_o = w_fwd_dat;
         end
      end
   end

endmodule

// File: tb/tb_multi_project_mux.sv
// Bench for multi_project_mux: reset sequence, project switching, GAP
// restart, forwarded reads, ack timeout, address boundaries, "none" select
// and reset during an access. Bus read results go through a scoreboard queue.
module tb_multi_project_mux;

   localparam int          NUM_PROJ = 8;
   localparam int          IO_W     = 38;
   localparam logic [31:0] BASE     = 32'h3000_0000;
   localparam int          GAP_CYC  = 4;
   localparam int          RST_CYC  = 8;
   localparam int          TIMEOUT  = 255;

   logic                     clk = 1'b0;
   logic                     reset;
   logic                     wbs_cyc_i, wbs_stb_i, wbs_we_i;
   logic [3:0]               wbs_sel_i;
   logic [31:0]              wbs_adr_i, wbs_dat_i;
   logic                     wbs_ack_o;
   logic [31:0]              wbs_dat_o;
   logic [IO_W-1:0]          io_in, io_out, io_oeb;
   logic [NUM_PROJ*IO_W-1:0] proj_io_in, proj_io_out, proj_io_oeb;
   logic [NUM_PROJ-1:0]      proj_reset, proj_wb_stb, proj_wb_ack;
   logic [NUM_PROJ*32-1:0]   proj_wb_dat;

   int          total = 0;
   int          bad   = 0;
   logic [31:0] exp_q[$];
   logic [7:0]  exp_sw = 8'd0;
   logic [7:0]  exp_to = 8'd0;

   multi_project_mux #(
      .NUM_PROJ (NUM_PROJ), .IO_W (IO_W), .BASE (BASE),
      .GAP_CYC (GAP_CYC), .RST_CYC (RST_CYC), .TIMEOUT (TIMEOUT)
   ) dut (
      .clk (clk), .reset (reset),
      .wbs_cyc_i (wbs_cyc_i), .wbs_stb_i (wbs_stb_i), .wbs_we_i (wbs_we_i),
      .wbs_sel_i (wbs_sel_i), .wbs_adr_i (wbs_adr_i), .wbs_dat_i (wbs_dat_i),
      .wbs_ack_o (wbs_ack_o), .wbs_dat_o (wbs_dat_o),
      .io_in (io_in), .io_out (io_out), .io_oeb (io_oeb),
      .proj_io_in (proj_io_in), .proj_io_out (proj_io_out), .proj_io_oeb (proj_io_oeb),
      .proj_reset (proj_reset), .proj_wb_stb (proj_wb_stb),
      .proj_wb_ack (proj_wb_ack), .proj_wb_dat (proj_wb_dat)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   // Bus master: one access, bounded wait for ack, returns data and latency
   task automatic wb_xfer(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                          input logic [31:0] wdat, input int max_cyc,
                          output logic [31:0] rdat, output int lat, output bit got);
      @(posedge clk); #1;
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
      wbs_sel_i = sel;  wbs_adr_i = adr;  wbs_dat_i = wdat;
      got = 1'b0; lat = -1; rdat = '0;
      for (int i = 0; i < max_cyc && !got; i++) begin
         @(negedge clk);
         if (wbs_ack_o === 1'b1) begin
            got = 1'b1; lat = i; rdat = wbs_dat_o;
         end
      end
      @(posedge clk); #1;
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
      wbs_sel_i = '0;   wbs_adr_i = '0;   wbs_dat_i = '0;
   endtask

   task automatic test_reset();
      logic [31:0] rd, e; int lat; bit got;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++;
      if (wbs_ack_o !== 1'b0 || wbs_dat_o !== 32'd0) begin
         bad++; $display("FAIL reset_bus ack=%b dat=%h want ack=0 dat=0", wbs_ack_o, wbs_dat_o);
      end
      total++;
      if (proj_reset !== '1) begin
         bad++; $display("FAIL reset_proj_reset got=%b want all ones", proj_reset);
      end
      @(posedge clk); #1 reset = 1'b0;
      for (int i = 0; i < RST_CYC; i++) begin
         @(negedge clk);
         total++;
         if (io_oeb !== '1 || io_out !== '0) begin
            bad++; $display("FAIL reset_gate cyc=%0d oeb=%h out=%h want oeb=all1 out=0", i, io_oeb, io_out);
         end
         total++;
         if (proj_io_in[IO_W-1:0] !== io_in) begin
            bad++; $display("FAIL reset_prst_in cyc=%0d got=%h want=%h", i, proj_io_in[IO_W-1:0], io_in);
         end
      end
      @(negedge clk);
      total++;
      if (io_out !== proj_io_out[IO_W-1:0] || io_oeb !== proj_io_oeb[IO_W-1:0]) begin
         bad++; $display("FAIL reset_run0 out=%h oeb=%h want out=%h oeb=%h",
                         io_out, io_oeb, proj_io_out[IO_W-1:0], proj_io_oeb[IO_W-1:0]);
      end
      total++;
      if (proj_reset[0] !== 1'b0) begin
         bad++; $display("FAIL reset_release got=%b want=0", proj_reset[0]);
      end
      exp_q.push_back(32'h0000_0000);
      wb_xfer(BASE + 32'h4, 1'b0, 4'hF, 32'd0, 10, rd, lat, got);
      e = exp_q.pop_front();
      total++;
      if (!got || lat !== 1 || rd !== e) begin
         bad++; $display("FAIL reset_status got=%b lat=%0d dat=%h want ack lat=1 dat=%h", got, lat, rd, e);
      end
   endtask

   task automatic test_switch();
      logic [31:0] rd, e; int lat; bit got;
      exp_sw++;
      wb_xfer(BASE, 1'b1, 4'hF, 32'd3, 10, rd, lat, got);
      total++;
      if (!got || lat !== 1) begin
         bad++; $display("FAIL switch_ack got=%b lat=%0d want ack lat=1", got, lat);
      end
      // the ack cycle was the first GAP cycle
      for (int i = 1; i < GAP_CYC; i++) begin
         @(negedge clk);
         total++;
         if (io_oeb !== '1 || io_out !== '0 || proj_reset[3] !== 1'b1 ||
             proj_io_in[3*IO_W +: IO_W] !== '0) begin
            bad++; $display("FAIL switch_gap cyc=%0d oeb=%h out=%h rst3=%b in3=%h want gated, in3=0",
                            i, io_oeb, io_out, proj_reset[3], proj_io_in[3*IO_W +: IO_W]);
         end
      end
      for (int i = 0; i < RST_CYC; i++) begin
         @(negedge clk);
         total++;
         if (io_oeb !== '1 || proj_reset[3] !== 1'b1 || proj_io_in[3*IO_W +: IO_W] !== io_in) begin
            bad++; $display("FAIL switch_prst cyc=%0d oeb=%h rst3=%b in3=%h want gated, rst3=1, in3=%h",
                            i, io_oeb, proj_reset[3], proj_io_in[3*IO_W +: IO_W], io_in);
         end
      end
      @(negedge clk);
      total++;
      if (io_out !== proj_io_out[3*IO_W +: IO_W] || io_oeb !== proj_io_oeb[3*IO_W +: IO_W] ||
          proj_reset[3] !== 1'b0 || proj_reset[0] !== 1'b1) begin
         bad++; $display("FAIL switch_run3 out=%h oeb=%h rst=%b want out=%h oeb=%h rst3=0 rst0=1",
                         io_out, io_oeb, proj_reset, proj_io_out[3*IO_W +: IO_W], proj_io_oeb[3*IO_W +: IO_W]);
      end
      exp_q.push_back({8'd0, exp_to, exp_sw, 8'd0});
      wb_xfer(BASE + 32'h4, 1'b0, 4'hF, 32'd0, 10, rd, lat, got);
      e = exp_q.pop_front();
      total++;
      if (!got || rd !== e) begin
         bad++; $display("FAIL switch_status got=%b dat=%h want=%h", got, rd, e);
      end
   endtask

   task automatic test_restart();
      logic [31:0] rd; int lat; bit got; int n; bit seen_run;
      exp_sw++;
      wb_xfer(BASE, 1'b1, 4'hF, 32'd3, 10, rd, lat, got);
      repeat (GAP_CYC + 1) @(negedge clk);
      total++;
      if (proj_io_in[3*IO_W +: IO_W] !== io_in || proj_reset[3] !== 1'b1) begin
         bad++; $display("FAIL restart_in_prst in3=%h rst3=%b want in3=%h rst3=1",
                         proj_io_in[3*IO_W +: IO_W], proj_reset[3], io_in);
      end
      exp_sw++;
      wb_xfer(BASE, 1'b1, 4'hF, 32'd3, 10, rd, lat, got);
      total++;
      if (!got || lat !== 1) begin
         bad++; $display("FAIL restart_ack got=%b lat=%0d want ack lat=1", got, lat);
      end
      n = 0; seen_run = 1'b0;
      for (int i = 0; i < 40 && !seen_run; i++) begin
         @(negedge clk);
         if (i == 0) begin
            total++;
            if (proj_io_in[3*IO_W +: IO_W] !== '0 || io_oeb !== '1) begin
               bad++; $display("FAIL restart_gap in3=%h oeb=%h want in3=0 oeb=all1",
                               proj_io_in[3*IO_W +: IO_W], io_oeb);
            end
         end
         if (proj_reset[3] === 1'b0) seen_run = 1'b1;
         else n++;
      end
      total++;
      if (!seen_run || n !== GAP_CYC + RST_CYC - 1) begin
         bad++; $display("FAIL restart_len run=%b gated=%0d want run=1 gated=%0d",
                         seen_run, n, GAP_CYC + RST_CYC - 1);
      end
      total++;
      if (io_out !== proj_io_out[3*IO_W +: IO_W]) begin
         bad++; $display("FAIL restart_out got=%h want=%h", io_out, proj_io_out[3*IO_W +: IO_W]);
      end
   endtask

   task automatic test_forward();
      logic [31:0] rd, e; int lat; bit got;
      logic [NUM_PROJ-1:0] e_stb;
      e_stb = '0; e_stb[3] = 1'b1;
      proj_wb_dat[3*32 +: 32] = 32'h0000_1234;
      exp_q.push_back(32'h0000_1234);
      fork
         wb_xfer(BASE + 32'h400, 1'b0, 4'hF, 32'd0, 20, rd, lat, got);
         begin
            int n;
            n = 0;
            @(negedge clk);
            while (proj_wb_stb[3] !== 1'b1 && n < 10) begin
               @(negedge clk); n++;
            end
            total++;
            if (proj_wb_stb !== e_stb) begin
               bad++; $display("FAIL fwd_stb got=%b want=%b", proj_wb_stb, e_stb);
            end
            total++;
            if (wbs_ack_o !== 1'b0 || wbs_dat_o !== 32'd0) begin
               bad++; $display("FAIL fwd_idle_dat ack=%b dat=%h want ack=0 dat=0", wbs_ack_o, wbs_dat_o);
            end
            repeat (2) @(posedge clk);
            #1 proj_wb_ack[3] = 1'b1;
            @(posedge clk);
            #1 proj_wb_ack[3] = 1'b0;
         end
      join
      e = exp_q.pop_front();
      total++;
      if (!got || lat !== 2 || rd !== e) begin
         bad++; $display("FAIL fwd_read got=%b lat=%0d dat=%h want ack lat=2 dat=%h", got, lat, rd, e);
      end
   endtask

   task automatic test_timeout();
      logic [31:0] rd, e; int lat; bit got; bit stb_in_ack; bit saw_stb;
      stb_in_ack = 1'b0; saw_stb = 1'b0;
      exp_to++;
      exp_q.push_back(32'hDEAD_BEEF);
      fork
         wb_xfer(BASE + 32'h400, 1'b0, 4'hF, 32'd0, TIMEOUT + 20, rd, lat, got);
         begin
            for (int i = 0; i < TIMEOUT + 20; i++) begin
               @(negedge clk);
               if (proj_wb_stb[3] === 1'b1) saw_stb = 1'b1;
               if (wbs_ack_o === 1'b1) begin
                  if (proj_wb_stb !== '0) stb_in_ack = 1'b1;
                  break;
               end
            end
         end
      join
      e = exp_q.pop_front();
      total++;
      if (!got || lat !== TIMEOUT || rd !== e) begin
         bad++; $display("FAIL timeout_ack got=%b lat=%0d dat=%h want lat=%0d dat=%h", got, lat, rd, TIMEOUT, e);
      end
      total++;
      if (!saw_stb || stb_in_ack) begin
         bad++; $display("FAIL timeout_stb saw=%b during_ack=%b want saw=1 during_ack=0", saw_stb, stb_in_ack);
      end
      exp_q.push_back({8'd0, exp_to, exp_sw, 8'd0});
      wb_xfer(BASE + 32'h4, 1'b0, 4'hF, 32'd0, 10, rd, lat, got);
      e = exp_q.pop_front();
      total++;
      if (!got || rd !== e) begin
         bad++; $display("FAIL timeout_status got=%b dat=%h want=%h", got, rd, e);
      end
   endtask

   task automatic test_boundary();
      logic [31:0] rd, e; int lat; bit got;
      // ACTIVE write without sel[0]: acked, no effect
      wb_xfer(BASE, 1'b1, 4'b0010, 32'd5, 10, rd, lat, got);
      total++;
      if (!got || lat !== 1) begin
         bad++; $display("FAIL bnd_sel0_ack got=%b lat=%0d want ack lat=1", got, lat);
      end
      @(negedge clk);
      total++;
      if (proj_reset[3] !== 1'b0 || io_out !== proj_io_out[3*IO_W +: IO_W]) begin
         bad++; $display("FAIL bnd_sel0_run rst3=%b out=%h want rst3=0 out=%h",
                         proj_reset[3], io_out, proj_io_out[3*IO_W +: IO_W]);
      end
      // we=1 with sel=0 is a read
      exp_q.push_back(32'd3);
      wb_xfer(BASE, 1'b1, 4'b0000, 32'd7, 10, rd, lat, got);
      e = exp_q.pop_front();
      total++;
      if (!got || rd !== e) begin
         bad++; $display("FAIL bnd_sel_none_read got=%b dat=%h want=%h", got, rd, e);
      end
      // one past the decoded span and one below BASE: never acked
      wb_xfer(BASE + 32'(NUM_PROJ + 1) * 32'h100, 1'b0, 4'hF, 32'd0, 8, rd, lat, got);
      total++;
      if (got) begin
         bad++; $display("FAIL bnd_above got ack=%b want no ack", got);
      end
      wb_xfer(BASE - 32'h4, 1'b0, 4'hF, 32'd0, 8, rd, lat, got);
      total++;
      if (got) begin
         bad++; $display("FAIL bnd_below got ack=%b want no ack", got);
      end
      // last word of the last window: inactive project, local ack with 0
      proj_wb_dat[7*32 +: 32] = 32'hCAFE_0007;
      exp_q.push_back(32'd0);
      wb_xfer(BASE + 32'(NUM_PROJ + 1) * 32'h100 - 32'h4, 1'b0, 4'hF, 32'd0, 10, rd, lat, got);
      e = exp_q.pop_front();
      total++;
      if (!got || lat !== 1 || rd !== e) begin
         bad++; $display("FAIL bnd_last_win got=%b lat=%0d dat=%h want ack lat=1 dat=%h", got, lat, rd, e);
      end
   endtask

   task automatic test_none();
      logic [31:0] rd, e; int lat; bit got; bit any_stb;
      exp_sw++;
      wb_xfer(BASE, 1'b1, 4'hF, 32'd200, 10, rd, lat, got);
      for (int i = 0; i < GAP_CYC + RST_CYC + 20; i++) begin
         @(negedge clk);
         total++;
         if (io_out !== '0 || io_oeb !== '1 || proj_reset !== '1 || proj_io_in !== '0) begin
            bad++; $display("FAIL none_gate cyc=%0d out=%h oeb=%h rst=%b want out=0 oeb=all1 rst=all1 in=0",
                            i, io_out, io_oeb, proj_reset);
         end
      end
      any_stb = 1'b0;
      exp_q.push_back(32'd0);
      fork
         wb_xfer(BASE + 32'h200, 1'b0, 4'hF, 32'd0, 10, rd, lat, got);
         begin
            for (int i = 0; i < 4; i++) begin
               @(negedge clk);
               if (proj_wb_stb !== '0) any_stb = 1'b1;
            end
         end
      join
      e = exp_q.pop_front();
      total++;
      if (!got || lat !== 1 || rd !== e || any_stb) begin
         bad++; $display("FAIL none_win_read got=%b lat=%0d dat=%h stb=%b want lat=1 dat=%h stb=0",
                         got, lat, rd, any_stb, e);
      end
      exp_q.push_back({8'd0, exp_to, exp_sw, 8'd0});
      wb_xfer(BASE + 32'h4, 1'b0, 4'hF, 32'd0, 10, rd, lat, got);
      e = exp_q.pop_front();
      total++;
      if (!got || rd !== e) begin
         bad++; $display("FAIL none_status got=%b dat=%h want=%h", got, rd, e);
      end
   endtask

   task automatic test_reset_abort();
      logic [31:0] rd, e; int lat; bit got;
      wb_xfer(BASE, 1'b1, 4'hF, 32'd3, 10, rd, lat, got);
      repeat (GAP_CYC + RST_CYC + 2) @(negedge clk);
      @(posedge clk); #1;
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
      wbs_sel_i = 4'hF; wbs_adr_i = BASE + 32'h400;
      repeat (5) @(negedge clk);
      total++;
      if (proj_wb_stb[3] !== 1'b1) begin
         bad++; $display("FAIL abort_pre_stb got=%b want=1", proj_wb_stb[3]);
      end
      @(posedge clk); #1 reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         total++;
         if (proj_wb_stb !== '0 || wbs_ack_o !== 1'b0 || wbs_dat_o !== 32'd0) begin
            bad++; $display("FAIL abort_in_reset cyc=%0d stb=%b ack=%b dat=%h want all 0",
                            i, proj_wb_stb, wbs_ack_o, wbs_dat_o);
         end
         if (i == 0) begin
            @(posedge clk); #1;
         end
      end
      @(posedge clk); #1;
      reset = 1'b0; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_sel_i = '0; wbs_adr_i = '0;
      @(negedge clk);
      total++;
      if (wbs_ack_o !== 1'b0) begin
         bad++; $display("FAIL abort_after ack=%b want=0", wbs_ack_o);
      end
      exp_sw = 8'd0; exp_to = 8'd0;
      exp_q.push_back({8'd0, exp_to, exp_sw, 8'd2});
      wb_xfer(BASE + 32'h4, 1'b0, 4'hF, 32'd0, 10, rd, lat, got);
      e = exp_q.pop_front();
      total++;
      if (!got || rd !== e) begin
         bad++; $display("FAIL abort_status got=%b dat=%h want=%h", got, rd, e);
      end
      exp_q.push_back(32'd0);
      wb_xfer(BASE, 1'b0, 4'hF, 32'd0, 10, rd, lat, got);
      e = exp_q.pop_front();
      total++;
      if (!got || rd !== e) begin
         bad++; $display("FAIL abort_active got=%b dat=%h want=%h", got, rd, e);
      end
   endtask

   initial begin
      reset = 1'b1;
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
      wbs_sel_i = '0;   wbs_adr_i = '0;   wbs_dat_i = '0;
      io_in = IO_W'({$urandom(), $urandom()});
      proj_wb_ack = '0;
      proj_wb_dat = '0;
      for (int k = 0; k < NUM_PROJ; k++) begin
         proj_io_out[k*IO_W +: IO_W] = IO_W'({$urandom(), $urandom()});
         proj_io_oeb[k*IO_W +: IO_W] = IO_W'({$urandom(), $urandom()}) & ~(IO_W'(1) << k);
      end
      test_reset();
      test_switch();
      test_restart();
      test_forward();
      test_timeout();
      test_boundary();
      test_none();
      test_reset_abort();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
